// File: rtl/flash_bpi_seq.sv
// flash_bpi_seq: single-word read/write sequencer for a 16-bit BPI NOR flash with WAIT handling.
// Optional WAIT timeout is enabled by defining FLASH_BPI_SEQ_WAIT_TIMEOUT_EN.
module flash_bpi_seq #(
    parameter int   T_SETUP  = 2,
    parameter int   T_RD     = 8,
    parameter int   T_WR     = 4,
    parameter int   T_HOLD   = 2,
    parameter logic WAIT_ACT = 1'b1,
    parameter int   TO_CYC   = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [23:0] flash_addr,
    output logic [15:0] flash_dq_o,
    output logic        flash_dq_oe,
    input  logic [15:0] flash_dq_i,
    input  logic        flash_wait,
    output logic        flash_we_n,
    output logic        flash_oe_n,
    output logic        flash_ce_n
);
    localparam int TA   = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
    localparam int TS   = (T_RD > T_WR) ? T_RD : T_WR;
    localparam int TMAX = (TA > TS) ? TA : TS;
    localparam int CW   = $clog2(TMAX + 1);

    if (T_SETUP < 1 || T_RD < 1 || T_WR < 1 || T_HOLD < 1 || TO_CYC < 1) begin : g_bad_param
        $error("flash_bpi_seq: timing parameters must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAITX, HOLD, RESP} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          wr, wr_d;
    logic          wait_m, wait_s;
    logic [23:0]   addr_d;
    logic [15:0]   dq_d, rdata_d;
    logic          dq_oe_d, we_n_d, oe_n_d, ce_n_d, rsp_valid_d, err_d;
    logic          rel, tmo, done;

    assign rel = wait_s != WAIT_ACT;

`ifdef FLASH_BPI_SEQ_WAIT_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYC + 1);
    logic [TW-1:0] to_cnt, to_inc;
    assign to_inc = to_cnt + 1'b1;
    assign tmo    = (state == WAITX) && !rel && (to_inc == TW'(TO_CYC));
    // Held at zero outside WAITX so every WAITX entry starts a fresh count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            to_cnt <= '0;
        else
            to_cnt <= (state == WAITX) ? to_inc : '0;
    end
`else
    assign tmo = 1'b0;
`endif

    assign done = (state == STROBE && cnt == '0 && rel) || (state == WAITX && (rel || tmo));

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        wr_d        = wr;
        addr_d      = flash_addr;
        dq_d        = flash_dq_o;
        dq_oe_d     = flash_dq_oe;
        we_n_d      = flash_we_n;
        oe_n_d      = flash_oe_n;
        ce_n_d      = flash_ce_n;
        rsp_valid_d = rsp_valid;
        rdata_d     = rsp_rdata;
        err_d       = rsp_err;
        case (state)
            IDLE: if (req_valid && req_ready) begin
                state_d = SETUP;
                cnt_d   = CW'(T_SETUP - 1);
                wr_d    = req_write;
                addr_d  = req_addr;
                dq_d    = req_wdata;
                dq_oe_d = req_write;
                ce_n_d  = 1'b0;
            end
            SETUP: if (cnt == '0) begin
                state_d = STROBE;
                oe_n_d  = wr;
                we_n_d  = !wr;
                cnt_d   = wr ? CW'(T_WR - 1) : CW'(T_RD - 1);
            end else begin
                cnt_d = cnt - 1'b1;
            end
            STROBE: if (cnt != '0)
                cnt_d = cnt - 1'b1;
            else if (!rel)
                state_d = WAITX;
            WAITX: ;
            // Pins return to their reset values so IDLE looks identical to reset.
            HOLD: if (cnt == '0) begin
                state_d     = RESP;
                ce_n_d      = 1'b1;
                dq_oe_d     = 1'b0;
                addr_d      = '0;
                dq_d        = '0;
                rsp_valid_d = 1'b1;
            end else begin
                cnt_d = cnt - 1'b1;
            end
            RESP: if (rsp_ready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                err_d       = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (done) begin
            state_d = HOLD;
            cnt_d   = CW'(T_HOLD - 1);
            oe_n_d  = 1'b1;
            we_n_d  = 1'b1;
            if (tmo) begin
                rdata_d = 16'hFFFF;
                err_d   = 1'b1;
            end else if (!wr) begin
                rdata_d = flash_dq_i;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_m <= 1'b0;
            wait_s <= 1'b0;
        end else begin
            wait_m <= flash_wait;
            wait_s <= wait_m;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            cnt         <= '0;
            wr          <= 1'b0;
            flash_addr  <= '0;
            flash_dq_o  <= '0;
            flash_dq_oe <= 1'b0;
            flash_we_n  <= 1'b1;
            flash_oe_n  <= 1'b1;
            flash_ce_n  <= 1'b1;
            req_ready   <= 1'b0;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            wr          <= wr_d;
            flash_addr  <= addr_d;
            flash_dq_o  <= dq_d;
            flash_dq_oe <= dq_oe_d;
            flash_we_n  <= we_n_d;
            flash_oe_n  <= oe_n_d;
            flash_ce_n  <= ce_n_d;
            req_ready   <= state_d == IDLE;
            busy        <= state_d != IDLE;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rdata_d;
            rsp_err     <= err_d;
        end
    end
endmodule

// File: tb/tb_flash_bpi_seq.sv
// tb_flash_bpi_seq: directed scoreboard bench for flash_bpi_seq; a monitor checks each response
// against the queued expectation, including latency and per-pin strobe cycle counts.
module tb_flash_bpi_seq;
`ifdef FLASH_BPI_SEQ_WAIT_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 255;
`endif

    logic        CLK = 1'b0, RST = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1, flash_wait = 1'b0;
    logic [23:0] req_addr = '0;
    logic [15:0] req_wdata = '0, rd_val = '0;
    logic        req_ready, rsp_valid, rsp_err, busy, flash_dq_oe, flash_we_n, flash_oe_n, flash_ce_n;
    logic [15:0] rsp_rdata, flash_dq_o, flash_dq_i;
    logic [23:0] flash_addr;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat, ce, oe, we, dq;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    int          tests = 0, fails = 0;
    int          cyc = 0, acc_cyc = 0, ce_c = 0, oe_c = 0, we_c = 0, dq_c = 0, bad_c = 0;
    int          w_lo = 0, w_hi = 0;
    logic        wait_en = 1'b0, seen = 1'b0;
    logic [23:0] cur_addr = '0;
    logic [15:0] cur_wd = '0;

    // Flash model: drives the read value only while OE_N is low.
    assign flash_dq_i = flash_oe_n ? 16'h0000 : rd_val;

    flash_bpi_seq #(.TO_CYC(TO)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .flash_addr(flash_addr), .flash_dq_o(flash_dq_o), .flash_dq_oe(flash_dq_oe),
        .flash_dq_i(flash_dq_i), .flash_wait(flash_wait),
        .flash_we_n(flash_we_n), .flash_oe_n(flash_oe_n), .flash_ce_n(flash_ce_n)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_rsp(input logic [15:0] rdata, input logic err, input int lat,
                              input int ce, input int oe, input int we, input int dq);
        exp_t x;
        x.rdata = rdata; x.err = err; x.lat = lat; x.ce = ce; x.oe = oe; x.we = we; x.dq = dq;
        sbq.push_back(x);
    endtask

    task automatic issue(input logic w, input logic [23:0] a, input logic [15:0] d);
        int n = 0;
        while (!req_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!req_ready) begin
            tests++; fails++;
            $display("FAIL issue_ready_timeout: req_ready stayed 0");
        end
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        @(negedge CLK);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        @(negedge CLK);
        while (!req_ready && n < lim) begin
            @(negedge CLK);
            n++;
        end
        if (!req_ready) begin
            tests++; fails++;
            $display("FAIL done_timeout: req_ready stayed 0 after %0d cycles", lim);
        end
    endtask

    // Accept happens at this edge: start of a transaction's cycle accounting.
    always @(posedge CLK) begin
        if (req_valid && req_ready) begin
            acc_cyc = cyc;
            ce_c = 0; oe_c = 0; we_c = 0; dq_c = 0; bad_c = 0;
            cur_addr = req_addr;
            cur_wd = req_wdata;
        end
    end

    always @(negedge CLK) begin
        cyc++;
        if (!flash_ce_n) ce_c++;
        if (!flash_oe_n) oe_c++;
        if (!flash_we_n) we_c++;
        if (flash_dq_oe) dq_c++;
        if ((!flash_oe_n && (!flash_we_n || flash_dq_oe)) || ((!flash_oe_n || !flash_we_n) && flash_ce_n) ||
            (!flash_ce_n && flash_addr != cur_addr) || (flash_dq_oe && flash_dq_o != cur_wd))
            bad_c++;
        flash_wait = (wait_en && (cyc - acc_cyc) >= w_lo && (cyc - acc_cyc) <= w_hi) ? 1'b1 : 1'b0;
        if (rsp_valid && !seen) begin
            seen = 1'b1;
            if (sbq.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_rsp: rdata %0h with empty scoreboard", rsp_rdata);
            end else begin
                e = sbq.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", rsp_err, e.err);
                chk("latency", cyc - acc_cyc, e.lat);
                chk("ce_low_cycles", ce_c, e.ce);
                chk("oe_low_cycles", oe_c, e.oe);
                chk("we_low_cycles", we_c, e.we);
                chk("dq_oe_cycles", dq_c, e.dq);
                chk("pin_rule_violations", bad_c, 0);
            end
        end
        if (!rsp_valid) seen = 1'b0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1 RST = 1'b1;
        #2;
        chk("reset_ctl", {flash_ce_n, flash_we_n, flash_oe_n, flash_dq_oe, req_ready, rsp_valid, busy, rsp_err},
            8'b1110_0000);
        chk("reset_bus", {flash_addr, flash_dq_o, rsp_rdata}, 56'h0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("idle_ready", {req_ready, busy}, 2'b10);

        rd_val = 16'hBEEF;
        expect_rsp(16'hBEEF, 1'b0, 13, 12, 8, 0, 0);
        issue(1'b0, 24'h001234, 16'h0);
        wait_done(100);

        expect_rsp(16'hBEEF, 1'b0, 9, 8, 0, 4, 8);
        issue(1'b1, 24'hABCDEF, 16'h5A5A);
        wait_done(100);

        rd_val = 16'h2468; w_lo = 8; w_hi = 12; wait_en = 1'b1;
        expect_rsp(16'h2468, 1'b0, 18, 17, 13, 0, 0);
        issue(1'b0, 24'h000100, 16'h0);
        wait_done(100);
        wait_en = 1'b0;

        rd_val = 16'hC0DE; rsp_ready = 1'b0;
        expect_rsp(16'hC0DE, 1'b0, 13, 12, 8, 0, 0);
        issue(1'b0, 24'h000042, 16'h0);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge CLK);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("resp_hold", {rsp_valid, req_ready, busy, rsp_rdata}, {3'b101, 16'hC0DE});
            req_write = 1'b1; req_addr = 24'h555555; req_valid = (i >= 3 && i <= 5);
            @(negedge CLK);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge CLK);
        chk("resp_release", {rsp_valid, busy, req_ready}, 3'b001);
        @(negedge CLK);
        chk("pulse_ignored", {busy, req_ready}, 2'b01);

        issue(1'b1, 24'h0F0F0F, 16'hA5A5);
        n = 0;
        while (flash_we_n && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("we_reached", flash_we_n, 1'b0);
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("midop_reset", {flash_ce_n, flash_we_n, flash_oe_n, flash_dq_oe, busy, req_ready, rsp_valid},
            7'b1110_000);
        chk("midop_reset_bus", {flash_addr, flash_dq_o, rsp_rdata}, 56'h0);
        @(negedge CLK);
        RST = 1'b0;

        rd_val = 16'h7777;
        expect_rsp(16'h7777, 1'b0, 13, 12, 8, 0, 0);
        issue(1'b0, 24'hFFFFFF, 16'h0);
        wait_done(100);

        expect_rsp(16'h7777, 1'b0, 9, 8, 0, 4, 8);
        issue(1'b1, 24'h000001, 16'h1111);
        wait_done(100);

`ifdef FLASH_BPI_SEQ_WAIT_TIMEOUT_EN
        rd_val = 16'h9999; w_lo = 8; w_hi = 1000000; wait_en = 1'b1;
        expect_rsp(16'hFFFF, 1'b1, 29, 28, 24, 0, 0);
        issue(1'b0, 24'h000200, 16'h0);
        wait_done(200);
        wait_en = 1'b0;
        chk("err_cleared", rsp_err, 1'b0);

        rd_val = 16'h1357;
        expect_rsp(16'h1357, 1'b0, 13, 12, 8, 0, 0);
        issue(1'b0, 24'h000300, 16'h0);
        wait_done(100);
`endif

        repeat (2) @(negedge CLK);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
